// File: rtl/averager_sequencer.sv
// Address/control sequencer for a BRAM accumulator that averages n_avg_max frames.
// Optional ping-pong banking is enabled by defining AVERAGER_SEQUENCER_PINGPONG_EN.
module averager_sequencer #(
  parameter int FAST_COUNT_WIDTH = 10,
  parameter int SLOW_COUNT_WIDTH = 16,
  parameter int OUT_DELAY        = 2
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        clken,
  input  logic                        restart,
  input  logic [FAST_COUNT_WIDTH-1:0] count_max,
  input  logic [SLOW_COUNT_WIDTH-1:0] n_avg_max,
  input  logic                        avg_on,
  input  logic                        continuous,
  output logic [FAST_COUNT_WIDTH:0]   address,
  output logic                        wen,
  output logic                        clr_fback,
  output logic                        ready,
  output logic                        read_bank,
  output logic [SLOW_COUNT_WIDTH-1:0] n_avg,
  output logic                        avg_on_out,
  output logic                        busy
);
  localparam int FW = FAST_COUNT_WIDTH;
  localparam int SW = SLOW_COUNT_WIDTH;

  typedef enum logic [1:0] {IDLE, ARM, FIRST, ACCUM} state_t;
  typedef struct packed {
    logic [FW:0] addr;
    logic        wen;
    logic        clr;
    logic        rdy;
  } out_t;

  state_t        state, state_nx;
  logic [FW-1:0] fast_cnt, cm_reg;
  logic [SW-1:0] n_avg_r, n_avg_nx, n_inc, nmax_reg;
  logic          avg_on_r, cont_reg, rdy_r, done, frame_end, load_cfg;
  logic          bank, read_bank_r;
  out_t          st, st_q;

  assign frame_end = clken && (fast_cnt == cm_reg);
  assign load_cfg  = (state == IDLE) || restart;
  assign n_inc     = n_avg_r + 1'b1;

  // Configuration is frozen for the duration of an acquisition.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cm_reg   <= count_max;
      nmax_reg <= '0;
      avg_on_r <= 1'b0;
      cont_reg <= 1'b0;
    end else if (load_cfg) begin
      cm_reg   <= count_max;
      nmax_reg <= n_avg_max;
      avg_on_r <= avg_on;
      cont_reg <= continuous;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        fast_cnt <= '0;
    else if (frame_end) fast_cnt <= '0;
    else if (clken)     fast_cnt <= fast_cnt + 1'b1;
  end

  always_comb begin
    state_nx = state;
    n_avg_nx = n_avg_r;
    done     = 1'b0;
    case (state)
      IDLE:  if (restart) state_nx = ARM;
      ARM:   if (frame_end) begin
               state_nx = FIRST;
               n_avg_nx = '0;
             end
      FIRST: if (restart) state_nx = ARM;
             else if (frame_end) begin
               n_avg_nx = SW'(1);
               if (!avg_on_r || nmax_reg <= SW'(1)) done = 1'b1;
               else state_nx = ACCUM;
             end
      ACCUM: if (restart) state_nx = ARM;
             else if (frame_end) begin
               n_avg_nx = n_inc;
               if (n_inc == nmax_reg) done = 1'b1;
             end
      default: state_nx = IDLE;
    endcase
    // Continuous mode rolls straight into the next first frame with no gap.
    if (done) begin
      state_nx = cont_reg ? FIRST : IDLE;
      if (cont_reg) n_avg_nx = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      n_avg_r <= '0;
      rdy_r   <= 1'b0;
    end else begin
      state   <= state_nx;
      n_avg_r <= n_avg_nx;
      rdy_r   <= done;
    end
  end

`ifdef AVERAGER_SEQUENCER_PINGPONG_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bank        <= 1'b0;
      read_bank_r <= 1'b0;
    end else if (done) begin
      read_bank_r <= bank;
      bank        <= ~bank;
    end
  end
`else
  assign bank        = 1'b0;
  assign read_bank_r = 1'b0;
`endif

  assign busy = (state == FIRST) || (state == ACCUM);

  always_comb begin
    st      = '0;
    st.addr = {bank, fast_cnt};
    st.wen  = clken && busy;
    st.clr  = (state == FIRST);
    st.rdy  = rdy_r;
  end

  // All write-side controls share one delay line so they stay aligned.
  generate
    if (OUT_DELAY == 0) begin : g_nodly
      assign st_q = st;
    end else begin : g_dly
      out_t pipe [OUT_DELAY];
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          for (int i = 0; i < OUT_DELAY; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= st;
          for (int i = 1; i < OUT_DELAY; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign st_q = pipe[OUT_DELAY-1];
    end
  endgenerate

  assign address    = st_q.addr;
  assign wen        = st_q.wen;
  assign clr_fback  = st_q.clr;
  assign ready      = st_q.rdy;
  assign read_bank  = read_bank_r;
  assign n_avg      = n_avg_r;
  assign avg_on_out = avg_on_r;
endmodule

// File: tb/tb_averager_sequencer.sv
// Scoreboard bench for averager_sequencer: expected write/ready streams per acquisition.
module tb_averager_sequencer;
  localparam int FW = 10;
  localparam int SW = 16;
  localparam int OD = 2;
`ifdef AVERAGER_SEQUENCER_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic clk = 0, resetn = 0, clken = 0, restart = 0, avg_on = 0, continuous = 0;
  logic [FW-1:0] count_max = '0;
  logic [SW-1:0] n_avg_max = '0;
  logic [FW:0]   address;
  logic          wen, clr_fback, ready, read_bank, avg_on_out, busy;
  logic [SW-1:0] n_avg;

  averager_sequencer #(.FAST_COUNT_WIDTH(FW), .SLOW_COUNT_WIDTH(SW), .OUT_DELAY(OD)) dut (
    .clk(clk), .resetn(resetn), .clken(clken), .restart(restart),
    .count_max(count_max), .n_avg_max(n_avg_max), .avg_on(avg_on), .continuous(continuous),
    .address(address), .wen(wen), .clr_fback(clr_fback), .ready(ready),
    .read_bank(read_bank), .n_avg(n_avg), .avg_on_out(avg_on_out), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    bit          rdy;
    int          id;
    logic [FW:0] addr;
    logic        clr;
    bit          first;
    int          nav;
    bit          chk_nav;
    logic        rbank;
    int          len;
  } item_t;

  item_t q[$];
  int n_tests = 0, n_fail = 0, cyc = 0, acq_id = 0, abort_id = -1;
  int rdy_cnt = 0, wr_cnt = 0, first_cyc = 0, last_rdy = -1, spacing = 0, cmode = 0;
  bit abort_pend = 0, model_bank = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(negedge clk);
    case (cmode)
      0:       clken = 1'b1;
      1:       clken = ~clken;
      default: clken = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected stream for one acquisition: every sample of every frame, then a ready.
  task automatic push_acq(input int cm, input int frames, input bit chk_nav, input int len);
    item_t it;
    logic b;
    b = PP ? model_bank : 1'b0;
    acq_id++;
    for (int f = 0; f < frames; f++)
      for (int i = 0; i <= cm; i++) begin
        it = '{rdy: 0, id: acq_id, addr: {b, FW'(i)}, clr: (f == 0), first: (f == 0 && i == 0),
               nav: 0, chk_nav: 0, rbank: 0, len: 0};
        q.push_back(it);
      end
    it = '{rdy: 1, id: acq_id, addr: '0, clr: 0, first: 0,
           nav: frames, chk_nav: chk_nav, rbank: b, len: len};
    q.push_back(it);
    if (PP) model_bank = ~model_bank;
  endtask

  task automatic start(input int cm, input int nmax, input bit av, input bit cont);
    @(negedge clk);
    count_max = FW'(cm); n_avg_max = SW'(nmax); avg_on = av; continuous = cont;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic mark_abort();
    abort_id   = acq_id;
    abort_pend = 1'b1;
    if (PP) model_bank = ~model_bank;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() > 0 && n < budget) begin @(negedge clk); n++; end
    chk("drain_left", q.size(), 0);
    q.delete();
    repeat (4) @(negedge clk);
  endtask

  always @(negedge clk) if (resetn) begin
    item_t it;
    if (abort_pend && !wen) begin
      while (q.size() > 0 && q[0].id == abort_id) void'(q.pop_front());
      abort_pend = 1'b0;
    end
    if (ready) begin
      if (q.size() == 0 || !q[0].rdy) begin
        n_tests++; n_fail++;
        $display("FAIL ready_unexpected: got 1 expected 0 (t=%0t)", $time);
      end else begin
        it = q.pop_front();
        chk("read_bank", read_bank, it.rbank);
        if (it.chk_nav) chk("n_avg_at_ready", n_avg, it.nav);
        if (it.len > 0) chk("acq_length", cyc - first_cyc, it.len);
        if (spacing > 0 && last_rdy >= 0) chk("ready_spacing", cyc - last_rdy, spacing);
        last_rdy = cyc;
        rdy_cnt++;
      end
    end
    if (wen) begin
      if (q.size() == 0 || q[0].rdy) begin
        n_tests++; n_fail++;
        $display("FAIL wen_unexpected: got 1 expected 0 addr=%0h (t=%0t)", address, $time);
      end else begin
        it = q.pop_front();
        chk("addr_clr", {address, clr_fback}, {it.addr, it.clr});
        if (it.first) first_cyc = cyc;
        wr_cnt++;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, wbase, n, cm, nmax, frames;
    bit av;
    repeat (3) @(negedge clk);
    chk("rst_wen", wen, 0);
    chk("rst_addr", address, 0);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_n_avg", n_avg, 0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    // single-shot, 4 averages of 16 samples
    push_acq(15, 4, 1, 64);
    start(15, 4, 1, 0);
    drain(3000);
    chk("ss_busy", busy, 0);
    chk("ss_n_avg", n_avg, 4);

    // averaging disabled: single frame
    push_acq(15, 1, 1, 16);
    start(15, 4, 0, 0);
    drain(3000);
    chk("noavg_avg_on_out", avg_on_out, 0);
    chk("noavg_n_avg", n_avg, 1);

    // continuous: 5 back-to-back acquisitions, then stop via restart
    last_rdy = -1; spacing = 32; base = rdy_cnt;
    for (int k = 0; k < 6; k++) push_acq(15, 2, 0, 32);
    start(15, 2, 1, 1);
    n = 0;
    while (rdy_cnt < base + 5 && n < 3000) begin @(negedge clk); n++; end
    chk("cont_readys", rdy_cnt - base, 5);
    spacing = 0;
    mark_abort();
    push_acq(15, 1, 1, 16);
    start(15, 1, 0, 0);
    drain(3000);
    chk("cont_total_readys", rdy_cnt - base, 6);

    // abort in the third frame, then a clean 4-frame acquisition
    base = rdy_cnt; wbase = wr_cnt;
    push_acq(15, 4, 1, 64);
    start(15, 4, 1, 0);
    n = 0;
    while (wr_cnt < wbase + 37 && n < 3000) begin @(negedge clk); n++; end
    chk("abort_progress", wr_cnt - wbase >= 37, 1);
    mark_abort();
    push_acq(15, 4, 1, 64);
    start(15, 4, 1, 0);
    drain(3000);
    chk("abort_readys", rdy_cnt - base, 1);

    // clken toggling every cycle
    cmode = 1; base = rdy_cnt; wbase = wr_cnt;
    push_acq(3, 2, 1, 15);
    start(3, 2, 1, 0);
    drain(3000);
    chk("toggle_writes", wr_cnt - wbase, 8);
    chk("toggle_readys", rdy_cnt - base, 1);

    // randomized single-shot acquisitions with random clken
    cmode = 2;
    for (int k = 0; k < 8; k++) begin
      cm = $urandom_range(0, 7); nmax = $urandom_range(0, 4); av = 1'($urandom_range(0, 1));
      frames = av ? ((nmax == 0) ? 1 : nmax) : 1;
      push_acq(cm, frames, 1, 0);
      start(cm, nmax, av, 0);
      drain(6000);
      chk("rand_busy", busy, 0);
    end

    // asynchronous reset in the middle of a frame
    cmode = 0;
    push_acq(15, 4, 1, 0);
    start(15, 4, 1, 0);
    repeat (20) @(negedge clk);
    #2 resetn = 1'b0;
    q.delete(); model_bank = 1'b0; abort_pend = 1'b0;
    #1;
    chk("arst_wen", wen, 0);
    chk("arst_addr", address, 0);
    chk("arst_clr", clr_fback, 0);
    chk("arst_busy", busy, 0);
    chk("arst_read_bank", read_bank, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    wbase = wr_cnt;
    repeat (20) @(negedge clk);
    chk("post_reset_no_wen", wr_cnt - wbase, 0);
    chk("post_reset_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
